// File: rtl/pampy_pkg.sv
// Shared constants and types for the instruction fetch queue.
//   OPC_*/ARG_* : bit slices of a program word (opcode high byte, argument low byte)
//   RESET_PC    : fetch address after reset
//   fetch_state_e : RUN (normal streaming) / FLUSH (stale reads still returning)
package pampy_pkg;

  localparam int OPC_MSB  = 15;
  localparam int OPC_LSB  = 8;
  localparam int ARG_MSB  = 7;
  localparam int ARG_LSB  = 0;

  localparam int RESET_PC = 0;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous in-order FIFO with read/write pointers one bit wider than the
// index, so full and empty are told apart by the extra MSB.
//   clk, rst_n   : clock, asynchronous active-low reset
//   flush        : empties the FIFO (wins over push/pop)
//   push, wdata  : write one entry (ignored when full without a pop)
//   pop          : remove the head (ignored when empty)
//   rdata, valid : head entry and non-empty flag
//   level        : number of occupied entries
module fetch_fifo #(
  parameter int WIDTH = 28,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdata,
  output logic                   valid,
  output logic [$clog2(DEPTH):0] level
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
  logic [LW-1:0]               wr_ptr_q, wr_ptr_d;
  logic [LW-1:0]               rd_ptr_q, rd_ptr_d;
  logic                        full, do_push, do_pop;

  assign level   = wr_ptr_q - rd_ptr_q;
  assign valid   = (level != '0);
  assign full    = (level == LW'(DEPTH));
  assign rdata   = mem_q[rd_ptr_q[PW-1:0]];
  // Push into a full FIFO is legal only when the head leaves the same cycle.
  assign do_pop  = pop && valid;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q[PW-1:0]] = wdata;
        wr_ptr_d = wr_ptr_q + LW'(1);
      end
      if (do_pop) rd_ptr_d = rd_ptr_q + LW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

endmodule

// File: rtl/instr_fetch_queue.sv
// Instruction fetch stage: issues sequential program-memory reads, splits each
// returned word into opcode/argument and queues {word, pc} for the control
// unit. A PC redirect empties the queue and discards reads still in flight.
//   clk, reset               : clock, asynchronous active-low reset
//   PC_LOAD, PC_LOAD_ADDR    : redirect strobe and target
//   MEM_REQ/ADDR/GNT         : read request channel
//   MEM_RVALID/RDATA         : in-order read response channel
//   FETCH_VALID/READY        : head handshake to control unit
//   INSTR_OUT, ARG_OUT, PC_OUT : head opcode, argument, fetch address
//   QUEUE_LEVEL              : occupied queue entries
module instr_fetch_queue
  import pampy_pkg::*;
#(
  parameter int DATA_WIDTH        = 8,
  parameter int ADDR_WIDTH        = 12,
  parameter int INSTRUCTION_WIDTH = 16,
  parameter int QUEUE_DEPTH       = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           PC_LOAD,
  input  logic [ADDR_WIDTH-1:0]          PC_LOAD_ADDR,
  output logic                           MEM_REQ,
  output logic [ADDR_WIDTH-1:0]          MEM_ADDR,
  input  logic                           MEM_GNT,
  input  logic                           MEM_RVALID,
  input  logic [INSTRUCTION_WIDTH-1:0]   MEM_RDATA,
  output logic                           FETCH_VALID,
  input  logic                           FETCH_READY,
  output logic [DATA_WIDTH-1:0]          INSTR_OUT,
  output logic [DATA_WIDTH-1:0]          ARG_OUT,
  output logic [ADDR_WIDTH-1:0]          PC_OUT,
  output logic [$clog2(QUEUE_DEPTH):0]   QUEUE_LEVEL
);

  localparam int             LW      = $clog2(QUEUE_DEPTH) + 1;
  localparam int             EW      = INSTRUCTION_WIDTH + ADDR_WIDTH;
  localparam logic [LW:0]    DEPTH_W = (LW+1)'(QUEUE_DEPTH);

  fetch_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0]   fetch_addr_q, fetch_addr_d;
  logic [LW-1:0]           outstanding_q, outstanding_d;
  logic [LW-1:0]           drop_q, drop_d;
  logic                    run_q, run_d;

  logic                    gnt, rv_ok, push, pop;
  logic [LW-1:0]           level;
  logic                    head_valid;
  logic [EW-1:0]           head_entry;
  logic [INSTRUCTION_WIDTH-1:0] head_word;
  logic [ADDR_WIDTH-1:0]   tag_addr;
  logic                    tag_valid_unused;
  logic [LW-1:0]           tag_level_unused;

  // run_q keeps MEM_REQ low during reset and in the first cycle after release.
  // Queue level plus reads in flight never exceeds the depth, so every
  // response always has a free slot.
  assign MEM_REQ  = run_q && !PC_LOAD &&
                    (({1'b0, level} + {1'b0, outstanding_q}) < DEPTH_W);
  assign MEM_ADDR = fetch_addr_q;
  assign gnt      = MEM_REQ && MEM_GNT;
  // A response with nothing outstanding is a protocol error and is ignored.
  assign rv_ok    = MEM_RVALID && (outstanding_q != '0);
  // A response arriving with a redirect belongs to the old stream.
  assign push     = rv_ok && (drop_q == '0) && !PC_LOAD;
  assign pop      = head_valid && FETCH_READY && !PC_LOAD;

  always_comb begin
    fetch_addr_d  = fetch_addr_q;
    outstanding_d = outstanding_q;
    drop_d        = drop_q;
    state_d       = state_q;
    run_d         = 1'b1;

    if (gnt)   outstanding_d = outstanding_d + LW'(1);
    if (rv_ok) outstanding_d = outstanding_d - LW'(1);

    if (PC_LOAD) begin
      // Everything still in flight after this cycle is stale.
      fetch_addr_d = PC_LOAD_ADDR;
      drop_d       = outstanding_d;
    end else begin
      if (gnt) fetch_addr_d = fetch_addr_q + ADDR_WIDTH'(1);
      if (rv_ok && (drop_q != '0)) drop_d = drop_q - LW'(1);
    end

    case (state_q)
      RUN:     if (PC_LOAD && (drop_d != '0)) state_d = FLUSH;
      FLUSH:   if (drop_d == '0) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= RUN;
      fetch_addr_q  <= ADDR_WIDTH'(RESET_PC);
      outstanding_q <= '0;
      drop_q        <= '0;
      run_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      fetch_addr_q  <= fetch_addr_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
      run_q         <= run_d;
    end
  end

  // Addresses of issued reads, popped as responses return (stale ones too),
  // so the head always names the address of the word now on MEM_RDATA.
  fetch_fifo #(.WIDTH(ADDR_WIDTH), .DEPTH(QUEUE_DEPTH)) u_tag_fifo (
    .clk   (clk),
    .rst_n (reset),
    .flush (1'b0),
    .push  (gnt),
    .wdata (fetch_addr_q),
    .pop   (rv_ok),
    .rdata (tag_addr),
    .valid (tag_valid_unused),
    .level (tag_level_unused)
  );

  fetch_fifo #(.WIDTH(EW), .DEPTH(QUEUE_DEPTH)) u_data_fifo (
    .clk   (clk),
    .rst_n (reset),
    .flush (PC_LOAD),
    .push  (push),
    .wdata ({MEM_RDATA, tag_addr}),
    .pop   (pop),
    .rdata (head_entry),
    .valid (head_valid),
    .level (level)
  );

  assign head_word   = head_entry[EW-1:ADDR_WIDTH];
  assign PC_OUT      = head_entry[ADDR_WIDTH-1:0];
  assign INSTR_OUT   = head_word[OPC_MSB:OPC_LSB];
  assign ARG_OUT     = head_word[ARG_MSB:ARG_LSB];
  assign FETCH_VALID = head_valid;
  assign QUEUE_LEVEL = level;

  a_rvalid_tracked: assert property (
    @(posedge clk) disable iff (!reset) MEM_RVALID |-> (outstanding_q != '0));

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Self-checking bench for instr_fetch_queue. A program memory model answers
// granted reads in order after a programmable latency. Every grant of the
// current stream is queued as an expected head; a redirect clears that queue.
// A separate monitor pops and compares each consumed head.
module tb_instr_fetch_queue;

  localparam int DW = 8, AW = 12, IW = 16, QD = 4, LW = $clog2(QD) + 1;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          PC_LOAD = 1'b0;
  logic [AW-1:0] PC_LOAD_ADDR = '0;
  logic          MEM_REQ;
  logic [AW-1:0] MEM_ADDR;
  logic          MEM_GNT = 1'b0;
  logic          MEM_RVALID = 1'b0;
  logic [IW-1:0] MEM_RDATA = '0;
  logic          FETCH_VALID;
  logic          FETCH_READY = 1'b0;
  logic [DW-1:0] INSTR_OUT, ARG_OUT;
  logic [AW-1:0] PC_OUT;
  logic [LW-1:0] QUEUE_LEVEL;

  instr_fetch_queue #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW),
                      .INSTRUCTION_WIDTH(IW), .QUEUE_DEPTH(QD)) dut (
    .clk(clk), .reset(reset), .PC_LOAD(PC_LOAD), .PC_LOAD_ADDR(PC_LOAD_ADDR),
    .MEM_REQ(MEM_REQ), .MEM_ADDR(MEM_ADDR), .MEM_GNT(MEM_GNT),
    .MEM_RVALID(MEM_RVALID), .MEM_RDATA(MEM_RDATA),
    .FETCH_VALID(FETCH_VALID), .FETCH_READY(FETCH_READY),
    .INSTR_OUT(INSTR_OUT), .ARG_OUT(ARG_OUT), .PC_OUT(PC_OUT),
    .QUEUE_LEVEL(QUEUE_LEVEL));

  always #5 clk = ~clk;

  typedef struct { logic [IW-1:0] data; int due; } rsp_t;
  typedef struct { logic [AW-1:0] pc; logic [IW-1:0] word; } exp_t;

  rsp_t          mem_q[$];
  exp_t          exp_q[$];
  logic [AW-1:0] exp_fetch = '0;
  int            tests = 0, fails = 0, pops = 0, cyc = 0;
  int            lat = 1, p_ready = 100, p_gnt = 100, p_load = 0;
  bit            mon_en = 1'b0, prev_load = 1'b0;

  function automatic logic [IW-1:0] word_of(input logic [AW-1:0] a);
    return IW'(32'(a) * 32'h0101);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // One clock cycle: drive inputs just after the edge, then record what the
  // coming edge will accept.
  task automatic step(input bit do_load, input logic [AW-1:0] tgt);
    rsp_t r;
    @(posedge clk); #1;
    cyc++;
    PC_LOAD      = do_load || ($urandom_range(99) < p_load);
    PC_LOAD_ADDR = do_load ? tgt : AW'($urandom);
    MEM_RVALID   = 1'b0;
    MEM_RDATA    = '0;
    if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      r = mem_q.pop_front();
      MEM_RVALID = 1'b1;
      MEM_RDATA  = r.data;
    end
    MEM_GNT     = ($urandom_range(99) < p_gnt);
    FETCH_READY = ($urandom_range(99) < p_ready);
    #1;
    if (MEM_REQ && MEM_GNT) mem_q.push_back('{word_of(MEM_ADDR), cyc + lat});
    if (PC_LOAD) begin
      chk("no_req_on_load", 32'(MEM_REQ), 0);
      exp_q.delete();
      exp_fetch = PC_LOAD_ADDR;
    end else if (MEM_REQ && MEM_GNT) begin
      chk("mem_addr", 32'(MEM_ADDR), 32'(exp_fetch));
      exp_q.push_back('{exp_fetch, word_of(exp_fetch)});
      exp_fetch++;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0);
  endtask

  task automatic wait_head(input string name, input logic [AW-1:0] pc, output int n);
    n = 0;
    for (int i = 0; i < 50; i++) begin
      step(1'b0, '0);
      n++;
      if (FETCH_VALID) begin
        chk(name, 32'(PC_OUT), 32'(pc));
        return;
      end
    end
    tests++;
    fails++;
    $display("FAIL %s: no head within 50 cycles, expected pc %0h", name, pc);
  endtask

  // Assert reset mid-cycle, check outputs clear at once, release on a falling edge.
  task automatic do_reset();
    mon_en = 1'b0;
    @(posedge clk); #3;
    reset = 1'b0;
    #1;
    chk("rst_mem_req",  32'(MEM_REQ), 0);
    chk("rst_mem_addr", 32'(MEM_ADDR), 0);
    chk("rst_valid",    32'(FETCH_VALID), 0);
    chk("rst_level",    32'(QUEUE_LEVEL), 0);
    chk("rst_pc",       32'(PC_OUT), 0);
    chk("rst_instr_arg", {INSTR_OUT, ARG_OUT}, 0);
    PC_LOAD = 1'b0; MEM_GNT = 1'b0; MEM_RVALID = 1'b0; FETCH_READY = 1'b0;
    mem_q.delete();
    exp_q.delete();
    exp_fetch = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("req_cycle0", 32'(MEM_REQ), 0);
    mon_en = 1'b1;
  endtask

  // Monitor: compare every consumed head against the scoreboard.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!mon_en) begin
      prev_load = 1'b0;
    end else begin
      if (prev_load) chk("valid_after_load", 32'(FETCH_VALID), 0);
      if (FETCH_VALID && FETCH_READY && !PC_LOAD) begin
        pops++;
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL head_unexpected: got pc %0h, expected no head", PC_OUT);
        end else begin
          e = exp_q.pop_front();
          chk("head_pc",    32'(PC_OUT),    32'(e.pc));
          chk("head_instr", 32'(INSTR_OUT), 32'(e.word[15:8]));
          chk("head_arg",   32'(ARG_OUT),   32'(e.word[7:0]));
        end
      end
      chk("level_bound", 32'(QUEUE_LEVEL <= LW'(QD)), 1);
      prev_load = PC_LOAD;
    end
  end

  initial begin
    int n, p0;
    // 1: stream from reset, latency 1, always ready
    do_reset();
    wait_head("t1_first_pc", 12'h000, n);
    chk("t1_latency", 32'(n), 3);
    p0 = pops;
    run(20);
    chk("t1_progress", 32'(pops - p0 >= 10), 1);

    // 2: back-pressure saturates the queue, then resumes in order
    do_reset();
    p_ready = 0;
    run(20);
    chk("t2_level_full", 32'(QUEUE_LEVEL), QD);
    chk("t2_req_off",    32'(MEM_REQ), 0);
    chk("t2_head_pc",    32'(PC_OUT), 0);
    p_ready = 100;
    p0 = pops;
    run(20);
    chk("t2_progress", 32'(pops - p0 >= 10), 1);

    // 3: redirect with reads in flight at latency 3
    lat = 3;
    run(12);
    step(1'b1, 12'h200);
    wait_head("t3_first_pc", 12'h200, n);
    run(20);

    // 4: redirect near the top of the address space wraps to 0
    lat = 2;
    step(1'b1, 12'hFFE);
    wait_head("t4_first_pc", 12'hFFE, n);
    p0 = pops;
    run(12);
    chk("t4_wrap_progress", 32'(pops - p0 >= 3), 1);

    // 5: redirect coinciding with grant and consume
    lat = 1;
    run(10);
    step(1'b1, 12'h123);
    chk("t5_valid_at_load", 32'(FETCH_VALID), 1);
    wait_head("t5_first_pc", 12'h123, n);
    run(10);

    // Randomized soak: stalls, sparse grants, redirects, varying latency
    p_load = 5; p_ready = 60; p_gnt = 70;
    for (int k = 0; k < 15; k++) begin
      lat = $urandom_range(1, 4);
      run(100);
    end
    p_load = 0; p_ready = 100; p_gnt = 100;
    run(20);

    // 6: asynchronous reset mid-stream, fetch restarts at 0
    do_reset();
    wait_head("t6_restart_pc", 12'h000, n);
    run(10);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
